data_in32_seq: RTL
==================

Name: data_in32_seq

Overview:
- Sequencer and buffer that feeds the 256-bit data-input datapath.
- Accepts 32-bit words one at a time over a valid/ready handshake and packs 8 of them into one 256-bit block.
- Drives the 3-bit state code `st` that the datapath consumes.
- Presents each completed block downstream with a valid/ready handshake.
- Sits between the serial word source and the 256-bit consumer (key/data load stage).

Parameters:
- DW, 32, width of one input word.
- NW, 8, words per block; the output width is DW*NW (256).
- CW, 16, width of the completed-block counter.

Ports:
- CLK  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  level; 1 = keep loading blocks back-to-back, 0 = return to IDLE after the current block is emitted.
- clr  input  1  synchronous abort; discards the partial block.
- in_valid  input  1  source has a word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  DW  input word.
- out_valid  output  1  PDO holds a complete block.
- out_ready  input  1  consumer takes the block.
- PDO  output  DW*NW  packed block; word k occupies bits [DW*k+DW-1 : DW*k].
- st  output  3  state code: 000 IDLE, 001 LOAD, 010 EMIT.
- word_cnt  output  3  number of words held in the current block (0..NW-1).
- blk_cnt  output  CW  number of blocks handed off; wraps.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - st=000, in_ready=0, out_valid=0, PDO=0, word_cnt=0, blk_cnt=0.
  - Reset mid-block discards all buffered words.
- State IDLE (000):
  - in_ready=0, out_valid=0.
  - Moves to LOAD on the next edge when run=1.
- State LOAD (001):
  - in_ready=1 combinationally (in_ready = st==LOAD).
  - A word is accepted when in_valid&in_ready. It is written into slot word_cnt of PDO and word_cnt increments.
  - The first word goes to slot 0 (bits 31:0).
  - Slots not yet written keep their previous contents and are not cleared between blocks.
  - When the accepted word is slot NW-1: word_cnt wraps to 0 and the next state is EMIT.
  - out_valid rises on the edge after the 8th word is accepted (latency 1 cycle).
  - Throughput: 1 word per cycle while in_valid is held high.
- State EMIT (010):
  - out_valid=1, in_ready=0.
  - PDO is held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: blk_cnt increments (wraps at 2^CW), out_valid falls next edge, and the next state is LOAD if run=1, else IDLE.
  - run is sampled on the handoff cycle only.
- run falling during LOAD:
  - The current block is completed and emitted, then the block goes to IDLE.
  - Partial blocks are never emitted.
- clr=1 (any state):
  - Next state IDLE, word_cnt=0, out_valid=0.
  - No word is accepted that cycle.
  - blk_cnt is unchanged and PDO contents are unchanged.
  - clr has priority over all handshakes.
- Simultaneous in_valid and out_ready in EMIT: no word is accepted, because in_ready=0.
- Illegal st encodings (011–111): recover to IDLE on the next edge.
- Outputs st, out_valid and PDO are registered. in_ready is decoded from registered state.

Decomposition:
- Shared package data_in32_pkg:
  - state typedef/localparams ST_IDLE=3'b000, ST_LOAD=3'b001, ST_EMIT=3'b010.
  - DW/NW defaults.
  - These encodings are reused by the 256-bit datapath.
- One natural sub-module: data_in32_pack. It holds the NW×DW slot register file, takes a write-enable plus slot index, and exposes the PDO bus.
- The FSM and counters stay in data_in32_seq.

Test Plan:
- Reset then run=1, feed words 0x11111111..0x88888888 with in_valid held high:
  - words are accepted on 8 consecutive cycles;
  - out_valid rises 1 cycle after the last word;
  - PDO = 0x88888888_77777777_..._11111111;
  - st sequence is 000→001→010.
- Hold out_ready=0 for 5 cycles in EMIT, driving in_valid=1:
  - in_ready=0 throughout and PDO stays stable;
  - on out_ready=1, blk_cnt goes 0→1 and st returns to 001.
- Gapped source: in_valid toggles every other cycle:
  - word_cnt advances only on handshake cycles;
  - the block completes after 8 accepted words (16 cycles).
- Pulse clr after 3 words: st=000, word_cnt=0, no out_valid. The next block packs correctly, starting from slot 0.
- run=0 during the 5th word: the block completes and is emitted, then st=000 and in_ready stays 0.
- Assert rst_n=0 mid-EMIT:
  - out_valid, st and blk_cnt are 0 immediately, without waiting for a clock edge;
  - after release with run=1, normal loading resumes.

Source files
------------

// File: rtl/data_in32_pkg.sv
// data_in32_pkg: state encodings and default widths shared by the sequencer and the 256-bit datapath
package data_in32_pkg;
  localparam int DW_DEF = 32;
  localparam int NW_DEF = 8;
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_EMIT = 3'b010
  } st_e;
endpackage

// File: rtl/data_in32_pack.sv
// data_in32_pack: NW x DW slot register file; writes one slot per enabled cycle and exposes it as a packed bus
//   clk, rst_n : clock, async active-low reset (clears all slots)
//   we, idx    : write enable and slot index
//   din        : word written into slot idx
//   pdo        : packed slots, slot k at [DW*k +: DW]
module data_in32_pack
  import data_in32_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [2:0]      idx,
  input  logic [DW-1:0]   din,
  output logic [DW*NW-1:0] pdo
);
  logic [DW-1:0] slot [NW];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '{default: '0};
    else if (we) slot[idx] <= din;
  for (genvar k = 0; k < NW; k++) begin : g_slot
    assign pdo[DW*k +: DW] = slot[k];
  end
endmodule

// File: rtl/data_in32_seq.sv
// data_in32_seq: packs NW DW-bit words into one block and hands it downstream over valid/ready
//   CLK, rst_n          : clock, async active-low reset
//   run, clr            : keep loading blocks / synchronous abort of the partial block
//   in_valid/in_ready   : word handshake, in_data is the word
//   out_valid/out_ready : block handshake, PDO is the block
//   st, word_cnt, blk_cnt : state code, words held, blocks handed off
module data_in32_seq
  import data_in32_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NW = NW_DEF,
  parameter int CW = 16
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW*NW-1:0] PDO,
  output logic [2:0]       st,
  output logic [2:0]       word_cnt,
  output logic [CW-1:0]    blk_cnt
);
  st_e st_q, st_d;
  logic acc, last, hand;
  assign in_ready = st_q == ST_LOAD;
  assign acc = in_valid & in_ready & ~clr;
  assign last = word_cnt == 3'(NW - 1);
  assign hand = out_valid & out_ready & ~clr;
  assign st = st_q;
  // run only matters at IDLE exit and on the handoff cycle; unknown codes fall back to IDLE
  always_comb begin
    st_d = ST_IDLE;
    if (!clr)
      case (st_q)
        ST_IDLE: st_d = run ? ST_LOAD : ST_IDLE;
        ST_LOAD: st_d = acc && last ? ST_EMIT : ST_LOAD;
        ST_EMIT: st_d = out_ready ? (run ? ST_LOAD : ST_IDLE) : ST_EMIT;
        default: st_d = ST_IDLE;
      endcase
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      out_valid <= 1'b0;
      word_cnt  <= '0;
      blk_cnt   <= '0;
    end else begin
      st_q      <= st_d;
      out_valid <= st_d == ST_EMIT;
      word_cnt  <= clr ? 3'd0 : acc ? (last ? 3'd0 : word_cnt + 3'd1) : word_cnt;
      blk_cnt   <= hand ? blk_cnt + CW'(1) : blk_cnt;
    end
  data_in32_pack #(.DW(DW), .NW(NW)) u_pack (
    .clk  (CLK),
    .rst_n(rst_n),
    .we   (acc),
    .idx  (word_cnt),
    .din  (in_data),
    .pdo  (PDO)
  );
endmodule
